led_pattern_engine: RTL and testbench

LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

---
 rtl/led_pattern_pkg.sv | 24 ++
 rtl/led_tick_gen.sv | 42 ++++
 rtl/led_pattern_engine.sv | 132 +++++++++++++
 tb/tb_led_pattern_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: pattern codes, LFSR constants and PWM width shared by the LED pattern engine.
// Revision: 1.0
`default_nettype none
package led_pattern_pkg;
  localparam logic [2:0] PAT_KNIGHT  = 3'd0;
  localparam logic [2:0] PAT_PAIR    = 3'd1;
  localparam logic [2:0] PAT_EXPAND  = 3'd2;
  localparam logic [2:0] PAT_BLINK   = 3'd3;
  localparam logic [2:0] PAT_ALT     = 3'd4;
  localparam logic [2:0] PAT_MARQUEE = 3'd5;
  localparam logic [2:0] PAT_SPARKLE = 3'd6;
  localparam logic [2:0] PAT_OFF     = 3'd7;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 map to state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int PWM_W = 4;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
// led_tick_gen: clk-domain step-rate divider producing a registered one-cycle tick, with pause/single-step.
// Revision: 1.0
`default_nettype none
module led_tick_gen #(
  parameter int DIV_W    = 24,
  parameter int FAST_DIV = 62500,
  parameter int SLOW_DIV = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic speed_sel,
  input  logic pause,
  input  logic step,
  output logic tick
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] term_m1;

  assign term_m1 = speed_sel ? DIV_W'(SLOW_DIV - 1) : DIV_W'(FAST_DIV - 1);

  // >= rather than == so a switch to the fast rate wraps at once instead of overrunning.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (ena) begin
        if (pause) begin
          if (step) tick <= 1'b1;
        end else if (cnt >= term_m1) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: tick-stepped LED pattern generator (knight, pair, expand, blink, alternate, marquee, sparkle, off).
// Optional brightness PWM when LED_PATTERN_PWM_DIM_EN is defined. Revision: 1.0
`default_nettype none
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int LED_W    = 8,
  parameter int DIV_W    = 24,
  parameter int FAST_DIV = 62500,
  parameter int SLOW_DIV = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [2:0]       pat_sel,
  input  logic             speed_sel,
  input  logic             pause,
  input  logic             step,
`ifdef LED_PATTERN_PWM_DIM_EN
  input  logic [3:0]       bright,
`endif
  output logic [LED_W-1:0] led_out,
  output logic [2:0]       pat_active
);
  localparam int H = LED_W / 2;

  logic             tick;
  logic [3:0]       pos;
  logic             dir;
  logic [LED_W-1:0] frame;
  logic [15:0]      lfsr;
  logic [4:0]       kn_nxt, pr_nxt;
  logic [3:0]       ex_nxt;

  led_tick_gen #(.DIV_W(DIV_W), .FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV)) u_tick (
    .clk(clk), .rst(rst), .ena(ena), .speed_sel(speed_sel),
    .pause(pause), .step(step), .tick(tick)
  );

  // Returns {dir, pos}; endpoints are shown once per bounce.
  function automatic logic [4:0] bounce(input logic [3:0] p, input logic d, input logic [3:0] top);
    if (!d) return (p >= top) ? {1'b1, p - 4'd1} : {1'b0, p + 4'd1};
    else    return (p == 4'd0) ? {1'b0, 4'd1} : {1'b1, p - 4'd1};
  endfunction

  function automatic logic [LED_W-1:0] knight_frame(input logic [3:0] p);
    logic [LED_W-1:0] f;
    for (int i = 0; i < LED_W; i++) f[i] = (i == int'(p)) || (i == LED_W - 1 - int'(p));
    return f;
  endfunction

  function automatic logic [LED_W-1:0] pair_frame(input logic [3:0] p);
    return {{(LED_W-2){1'b0}}, 2'b11} << p;
  endfunction

  function automatic logic [LED_W-1:0] expand_frame(input logic [3:0] idx);
    logic [LED_W-1:0] f;
    int k;
    if (int'(idx) < H)              k = int'(idx) + 1;
    else if (int'(idx) < 2 * H - 1) k = 2 * H - 1 - int'(idx);
    else                            k = 0;
    for (int i = 0; i < LED_W; i++) f[i] = (i >= H - k) && (i < H + k);
    return f;
  endfunction

  function automatic logic [LED_W-1:0] first_frame(input logic [2:0] code);
    logic [LED_W-1:0] f;
    case (code)
      PAT_KNIGHT:  f = knight_frame(4'd0);
      PAT_PAIR:    f = pair_frame(4'd0);
      PAT_EXPAND:  f = expand_frame(4'd0);
      PAT_BLINK:   f = '1;
      PAT_ALT:     for (int i = 0; i < LED_W; i++) f[i] = (i % 2 == 1);
      PAT_MARQUEE: f = {{(LED_W-3){1'b0}}, 3'b111};
      PAT_SPARKLE: f = LFSR_SEED[LED_W-1:0];
      default:     f = '0;
    endcase
    return f;
  endfunction

  always_comb begin
    kn_nxt = bounce(pos, dir, 4'(H - 1));
    pr_nxt = bounce(pos, dir, 4'(LED_W - 2));
    ex_nxt = (int'(pos) >= 2 * H - 1) ? 4'd0 : pos + 4'd1;
  end

  // A pattern change outranks any pending bounce reversal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame      <= '0;
      pat_active <= PAT_OFF;
      pos        <= '0;
      dir        <= 1'b0;
      lfsr       <= LFSR_SEED;
    end else if (ena && tick) begin
      if (pat_sel != pat_active) begin
        pat_active <= pat_sel;
        pos        <= '0;
        dir        <= 1'b0;
        lfsr       <= lfsr_next(LFSR_SEED);
        frame      <= first_frame(pat_sel);
      end else begin
        case (pat_active)
          PAT_KNIGHT:  begin pos <= kn_nxt[3:0]; dir <= kn_nxt[4]; frame <= knight_frame(kn_nxt[3:0]); end
          PAT_PAIR:    begin pos <= pr_nxt[3:0]; dir <= pr_nxt[4]; frame <= pair_frame(pr_nxt[3:0]); end
          PAT_EXPAND:  begin pos <= ex_nxt; frame <= expand_frame(ex_nxt); end
          PAT_BLINK,
          PAT_ALT:     frame <= ~frame;
          PAT_MARQUEE: frame <= {frame[LED_W-2:0], frame[LED_W-1]};
          PAT_SPARKLE: begin frame <= lfsr[LED_W-1:0]; lfsr <= lfsr_next(lfsr); end
          default:     frame <= '0;
        endcase
      end
    end
  end

`ifdef LED_PATTERN_PWM_DIM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic             pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign pwm_on  = (pwm_cnt < bright) || (bright == 4'hF);
  assign led_out = frame & {LED_W{pwm_on}};
`else
  assign led_out = frame;
`endif
endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed self-checking bench, 8- and 12-LED instances driven in lockstep.
// Revision: 1.0
`default_nettype none
module tb_led_pattern_engine;
  logic        clk = 1'b0, rst = 1'b1, ena = 1'b1, speed_sel = 1'b0, pause = 1'b0, step = 1'b0;
  logic [2:0]  pat_sel = 3'd0;
  logic [3:0]  bright = 4'hF;
  logic [7:0]  led8;
  logic [11:0] led12;
  logic [2:0]  pa8, pa12;
  int          total = 0, bad = 0;

  logic [7:0]  knight_exp [8]  = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h24, 8'h42, 8'h81, 8'h42};
  logic [7:0]  pair_exp   [9]  = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h60, 8'h30};
  logic [7:0]  exp8_e     [8]  = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h7E, 8'h3C, 8'h18, 8'h00};
  logic [11:0] exp12_e    [12] = '{12'h060, 12'h0F0, 12'h1F8, 12'h3FC, 12'h7FE, 12'hFFF,
                                   12'h7FE, 12'h3FC, 12'h1F8, 12'h0F0, 12'h060, 12'h000};

  always #5 clk = ~clk;

  led_pattern_engine #(.LED_W(8), .DIV_W(8), .FAST_DIV(4), .SLOW_DIV(10)) u_dut8 (
    .clk(clk), .rst(rst), .ena(ena), .pat_sel(pat_sel), .speed_sel(speed_sel),
    .pause(pause), .step(step),
`ifdef LED_PATTERN_PWM_DIM_EN
    .bright(bright),
`endif
    .led_out(led8), .pat_active(pa8)
  );

  led_pattern_engine #(.LED_W(12), .DIV_W(8), .FAST_DIV(4), .SLOW_DIV(10)) u_dut12 (
    .clk(clk), .rst(rst), .ena(ena), .pat_sel(pat_sel), .speed_sel(speed_sel),
    .pause(pause), .step(step),
`ifdef LED_PATTERN_PWM_DIM_EN
    .bright(bright),
`endif
    .led_out(led12), .pat_active(pa12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the 8-LED output to change; returns cycles waited.
  task automatic next_frame(output int cyc);
    logic [7:0] prev;
    prev = led8;
    cyc  = 0;
    while (led8 === prev && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (led8 === prev) check("frame_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int c;
    logic [7:0] held;
    repeat (3) @(negedge clk);
    check("rst_led8", led8, 8'h00);
    check("rst_pat", pa8, 3'd7);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      next_frame(c);
      check($sformatf("knight%0d", i), led8, knight_exp[i]);
      if (i > 0) check("knight_gap", c, 4);
    end
    check("knight_pat", pa8, 3'd0);

    pat_sel = 3'd1;
    for (int i = 0; i < 9; i++) begin
      next_frame(c);
      check($sformatf("pair%0d", i), led8, pair_exp[i]);
    end
    check("pair_pat", pa8, 3'd1);
    speed_sel = 1'b1;
    next_frame(c);
    check("pair_slow0", led8, 8'h18);
    next_frame(c);
    check("pair_slow1", led8, 8'h0C);
    check("slow_gap", c, 10);
    speed_sel = 1'b0;
    next_frame(c);
    check("pair_fast", led8, 8'h06);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    next_frame(c);
    check("step_nopause_val", led8, 8'h03);
    check("step_nopause_gap", c + 1, 4);

    pat_sel = 3'd2;
    next_frame(c);
    check("exp8_0", led8, exp8_e[0]);
    check("exp12_0", led12, exp12_e[0]);
    pause = 1'b1;
    repeat (50) @(negedge clk);
    check("pause8", led8, exp8_e[0]);
    check("pause12", led12, exp12_e[0]);
    for (int j = 0; j < 3; j++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("step8_%0d", j), led8, exp8_e[j+1]);
      check($sformatf("step12_%0d", j), led12, exp12_e[j+1]);
    end
    pause = 1'b0;
    for (int i = 4; i < 12; i++) begin
      next_frame(c);
      check($sformatf("exp12_%0d", i), led12, exp12_e[i]);
      check($sformatf("exp8_%0d", i), led8, exp8_e[i % 8]);
    end

    ena  = 1'b0;
    held = led8;
    pat_sel = 3'd4;
    repeat (20) @(negedge clk);
    check("ena_hold_led", led8, held);
    check("ena_hold_pat", pa8, 3'd2);
    ena = 1'b1;

    next_frame(c);
    check("alt0", led8, 8'hAA);
    next_frame(c);
    check("alt1", led8, 8'h55);
    pat_sel = 3'd3;
    next_frame(c);
    check("blink0", led8, 8'hFF);
    next_frame(c);
    check("blink1", led8, 8'h00);
    check("blink_pat", pa8, 3'd3);

    pat_sel = 3'd5;
    next_frame(c);
    check("marq0", led8, 8'h07);
    next_frame(c);
    check("marq1", led8, 8'h0E);
    pat_sel = 3'd6;
    repeat (2) @(negedge clk);
    check("sel_wait_led", led8, 8'h0E);
    check("sel_wait_pat", pa8, 3'd5);
    next_frame(c);
    check("spark0", led8, 8'hE1);
    check("spark0_12", led12, 12'hCE1);
    check("spark_pat", pa8, 3'd6);
    next_frame(c);
    check("spark1", led8, 8'hC3);
    check("spark1_12", led12, 12'h9C3);

    pat_sel = 3'd0;
    next_frame(c);
    check("rk0", led8, 8'h81);
    next_frame(c);
    check("rk1", led8, 8'h42);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_led", led8, 8'h00);
    check("async_rst_pat", pa8, 3'd7);
    @(negedge clk);
    rst = 1'b0;
    next_frame(c);
    check("post_rst_frame", led8, 8'h81);
    check("post_rst_pat", pa8, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
